// File: rtl/mem_writeback_pkg.sv
// Shared definitions for the memory/write-back stage: memwrite codes,
// FSM states and register-file address width.
package mem_writeback_pkg;

  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    MW_NONE  = 2'b00,
    MW_LOAD  = 2'b01,
    MW_STORE = 2'b10,
    MW_RSVD  = 2'b11   // behaves like MW_NONE
  } mw_e;

  typedef enum logic [1:0] {
    IDLE,
    MEMWAIT,
    WB,
    HALTED
  } state_e;

  // True when the instruction needs a data-memory transaction.
  function automatic logic is_mem_op(input logic [1:0] mw);
    return (mw == MW_LOAD) || (mw == MW_STORE);
  endfunction

endpackage

// File: rtl/mem_writeback_if.sv
// Data-memory request/acknowledge bus between the write-back stage
// (master) and the memory (slave).
interface mem_writeback_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_writeback.sv
// Memory / write-back pipeline stage. Accepts one instruction at a time,
// performs an optional load/store with an ack timeout, then issues a
// single-cycle register-file write strobe. A halt instruction parks the
// stage until reset.
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clockp4,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       aluresult,
  input  logic [15:0]       address,
  input  logic [15:0]       storedata,
  input  logic [1:0]        memwrite,
  input  logic              writereg,
  input  logic [REG_AW-1:0] regaddress,
  input  logic              halt,
  mem_writeback_if.master   mem,
  output logic              writeflag,
  output logic [REG_AW-1:0] writetarget,
  output logic [15:0]       aluwriteval,
  output logic [15:0]       readoutwriteval,
  output logic              readoutSelect,
  output logic              haltout,
  output logic              memerror
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e            state, state_d;
  logic [CW-1:0]     wait_cnt;
  logic [15:0]       lat_alu, lat_addr, lat_wdata, rdata_q;
  mw_e               lat_mw;
  logic              lat_wreg, lat_halt;
  logic [REG_AW-1:0] lat_rd;
  logic              timed_out, memerror_q;
  logic              ack_hit, timeout_hit;

  assign writetarget     = lat_rd;
  assign aluwriteval     = lat_alu;
  assign readoutwriteval = rdata_q;
  assign memerror        = memerror_q;

  // Next-state and per-state output decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    state_d       = state;
    in_ready      = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    writeflag     = 1'b0;
    readoutSelect = 1'b0;
    haltout       = 1'b0;
    ack_hit       = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = is_mem_op(memwrite) ? MEMWAIT : WB;
      end
      MEMWAIT: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = (lat_mw == MW_STORE);
        mem.mem_addr  = lat_addr;
        mem.mem_wdata = lat_wdata;
        if (mem.mem_ack) begin
          ack_hit = 1'b1;
          state_d = WB;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = WB;
        end
      end
      WB: begin
        writeflag     = lat_wreg && !timed_out && (lat_mw != MW_STORE);
        readoutSelect = (lat_mw == MW_LOAD);
        state_d       = lat_halt ? HALTED : IDLE;
      end
      HALTED: haltout = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // State register, instruction latches, wait counter and sticky error flag.
  always_ff @(posedge clockp4) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_alu    <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_mw     <= MW_NONE;
      lat_wreg   <= 1'b0;
      lat_rd     <= '0;
      lat_halt   <= 1'b0;
      rdata_q    <= '0;
      timed_out  <= 1'b0;
      memerror_q <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (in_valid) begin
          lat_alu   <= aluresult;
          lat_addr  <= address;
          lat_wdata <= storedata;
          lat_mw    <= mw_e'(memwrite);
          lat_wreg  <= writereg;
          lat_rd    <= regaddress;
          lat_halt  <= halt;
          rdata_q   <= '0;
          wait_cnt  <= '0;
          timed_out <= 1'b0;
        end
        MEMWAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (ack_hit && lat_mw == MW_LOAD) rdata_q <= mem.mem_rdata;
          if (timeout_hit) begin
            timed_out  <= 1'b1;
            memerror_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles waiting for mem_ack before abort.
REQ-002 clockp4  input  1  stage clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream instruction present this cycle.
REQ-005 in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 aluresult  input  16  execute-stage result.
REQ-007 address  input  16  data-memory address.
REQ-008 storedata  input  16  store data.
REQ-009 memwrite  input  2  00 none, 01 load, 10 store, 11 treated as none.
REQ-010 writereg  input  1  instruction writes a register.
REQ-011 regaddress  input  3  destination register.
REQ-012 halt  input  1  instruction is hlt.
REQ-013 mem_req, mem_we  output  1 each  memory request / write enable.
REQ-014 mem_addr, mem_wdata  output  16 each  memory address / write data.
REQ-015 mem_ack  input  1  memory completes current request.
REQ-016 mem_rdata  input  16  load data, valid when mem_ack=1.
REQ-017 writeflag  output  1  register-file write strobe.
REQ-018 writetarget  output  3  register to write.
REQ-019 aluwriteval, readoutwriteval  output  16 each  ALU / memory write-back value.
REQ-020 readoutSelect  output  1  1 selects readoutwriteval, 0 aluwriteval.
REQ-021 haltout, memerror  output  1 each  sticky halt / sticky memory-timeout flag.

Function
REQ-022 FSM states IDLE, MEMWAIT, WB, HALTED; in_ready=1 only in IDLE.
REQ-023 IDLE with in_valid=1 and memwrite in {00,11}: latch fields, go WB.
REQ-024 IDLE with in_valid=1 and memwrite in {01,10}: latch fields, go MEMWAIT; mem_req=1 from the next cycle.
REQ-025 MEMWAIT: mem_req=1, mem_addr/mem_wdata/mem_we (we=1 for store) held stable until the mem_ack cycle.
REQ-026 mem_ack=1 in MEMWAIT: capture mem_rdata for loads, drop mem_req next cycle, go WB.
REQ-027 mem_ack outside MEMWAIT is ignored.
REQ-028 Wait counter counts MEMWAIT cycles; reaching TIMEOUT without ack sets memerror, drops mem_req, goes WB with writeflag suppressed.
REQ-029 WB lasts exactly one cycle: writeflag=latched writereg (0 after timeout or for store), writetarget=latched regaddress, readoutSelect=1 for load else 0.
REQ-030 After WB: go HALTED if latched halt=1, else IDLE.
REQ-031 HALTED: in_ready=0, haltout=1, no requests, until reset.
REQ-032 Latency accept->writeflag: 1 cycle non-memory; ack-cycle+1 for memory ops.
REQ-033 writeflag is 0 in every state except WB.

Reset
REQ-034 reset=1: state IDLE, all outputs 0 except in_ready=1, counter 0, latches 0.
REQ-035 reset during MEMWAIT aborts the request: mem_req=0 next cycle, no write-back.
REQ-036 reset clears haltout and memerror.

Structure
REQ-037 Shared package holds memwrite codes (MW_NONE, MW_LOAD, MW_STORE), FSM state enum, register-address width.
REQ-038 Single module; no sub-modules.

Verification
REQ-039 ALU op aluresult=0x1234, writereg=1, regaddress=3 -> next cycle writeflag=1, writetarget=3, aluwriteval=0x1234, readoutSelect=0.
REQ-040 Load address=0x0010, regaddress=5, ack after 3 cycles with rdata=0xBEEF -> mem_req high 3 cycles, next cycle writeflag=1, writetarget=5, readoutwriteval=0xBEEF, readoutSelect=1.
REQ-041 Store address=0x0020, storedata=0x00FF, immediate ack -> mem_we=1, mem_wdata=0x00FF for one cycle, writeflag never 1.
REQ-042 Load with no ack, TIMEOUT=15 -> memerror=1 after 15 MEMWAIT cycles, no write, in_ready=1 two cycles later.
REQ-043 halt=1 with writereg=0 -> haltout=1, in_ready stays 0; further in_valid ignored until reset.
REQ-044 reset in 2nd MEMWAIT cycle -> mem_req=0, writeflag=0, in_ready=1 next cycle.
